// File: rtl/mem_responder_if.sv
// Bus-side signal bundle between the control unit and the memory responder.
// master = control unit / bus mux side, slave = memory responder.
interface mem_responder_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0] BusMuxOut;
   logic              MARin;
   logic              MDRin;
   logic              Read;
   logic              Write;
   logic [DATA_W-1:0] MDR_q;
   logic [ADDR_W-1:0] MAR_q;
   logic              Mem_Ready;
   logic              Busy;

   modport master (
      output BusMuxOut, MARin, MDRin, Read, Write,
      input  MDR_q, MAR_q, Mem_Ready, Busy
   );

   modport slave (
      input  BusMuxOut, MARin, MDRin, Read, Write,
      output MDR_q, MAR_q, Mem_Ready, Busy
   );
endinterface

// File: rtl/mem_responder.sv
// MAR/MDR plus synchronous RAM answering Read/Write strobes after a
// fixed number of wait states, with a one-cycle Mem_Ready pulse.
module mem_responder #(
   parameter int ADDR_W      = 9,
   parameter int WAIT_CYCLES = 1,
   parameter int DATA_W      = 32
) (
   input logic           Clock,
   input logic           Reset_n,
   mem_responder_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_HOLD
   } state_e;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [ADDR_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic [DATA_W-1:0] d_q, d_d;
   logic              wr_q, wr_d;
   logic              rdy_q, rdy_d;
   logic              busy_q, busy_d;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      d_d     = d_q;
      wr_d    = wr_q;
      rdy_d   = 1'b0;
      busy_d  = busy_q;
      ram_we  = 1'b0;
      mar_d   = bus.MARin ? bus.BusMuxOut[ADDR_W-1:0] : mar_q;
      mdr_d   = (bus.MDRin && !bus.Read) ? bus.BusMuxOut : mdr_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.Read || bus.Write) begin
               a_d     = mar_q;
               d_d     = mdr_q;
               wr_d    = !bus.Read;
               cnt_d   = WAIT_INIT;
               busy_d  = 1'b1;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // RAM data beats a same-edge bus load into MDR
               if (wr_q) ram_we = 1'b1;
               else      mdr_d  = ram_rdata;
               rdy_d   = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (!bus.Read && !bus.Write) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mar_q   <= '0;
         a_q     <= '0;
         mdr_q   <= '0;
         d_q     <= '0;
         wr_q    <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mar_q   <= mar_d;
         a_q     <= a_d;
         mdr_q   <= mdr_d;
         d_q     <= d_d;
         wr_q    <= wr_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
      end
   end

   // Read port tracks the next access address so data is ready by completion
   always_ff @(posedge Clock) begin
      if (ram_we) mem[a_q] <= d_q;
      ram_rdata <= mem[a_d];
   end

   assign bus.MDR_q     = mdr_q;
   assign bus.MAR_q     = mar_q;
   assign bus.Mem_Ready = rdy_q;
   assign bus.Busy      = busy_q;

endmodule
